// File: rtl/cmos_capture_multi_if.sv
// rtl/cmos_capture_multi_if.sv - gated pixel output bus of the CMOS capture block
//
// Purpose: bundles the synchronised pixel stream leaving cmos_capture_multi.
// Signals:
//   frame_vsync  gated frame-valid
//   frame_href   gated line-valid
//   frame_de     pixel-valid strobe, one cycle per assembled pixel
//   frame_data   assembled pixel, BYTES_PER_PIX*DATA_W bits, first beat in MSBs
//   pix_x/pix_y  coordinates of the pixel currently flagged by frame_de
// Modports: master = capture block (drives), slave = downstream consumer.
interface cmos_capture_multi_if #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 1,
  parameter int XY_W          = 12
);
  logic                            frame_vsync;
  logic                            frame_href;
  logic                            frame_de;
  logic [BYTES_PER_PIX*DATA_W-1:0] frame_data;
  logic [XY_W-1:0]                 pix_x;
  logic [XY_W-1:0]                 pix_y;

  modport master (
    output frame_vsync, frame_href, frame_de, frame_data, pix_x, pix_y
  );

  modport slave (
    input frame_vsync, frame_href, frame_de, frame_data, pix_x, pix_y
  );
endinterface

// File: rtl/cmos_capture_multi.sv
// rtl/cmos_capture_multi.sv - CMOS sensor capture with frame discard, pixel packing, geometry and fps measurement
//
// Purpose: registers the raw sensor bus twice, drops the first FRAME_WAITCNT
// frames after reset, packs BYTES_PER_PIX beats into one pixel, tracks pixel
// coordinates, measures line width / frame height and the frame rate over a
// two-second window.
// Ports:
//   cmos_pclk, rst_n        pixel clock (rising edge), async active-low reset
//   clk_cmos, cmos_xclk     sensor drive clock and its pass-through
//   cmos_vsync, cmos_href   frame-valid / line-valid from the sensor
//   cmos_data               sensor data beat
//   crop_x0/y0/w/h          crop window (only with CMOS_CAPTURE_CROP_EN)
//   frame_bus               gated pixel stream (cmos_capture_multi_if.master)
//   meas_width/meas_height  pixels in last line / lines in last frame
//   fps_rate                frames per second averaged over 2 s
// Optional feature macro: CMOS_CAPTURE_CROP_EN (crop window on the output).
module cmos_capture_multi #(
  parameter int FRAME_WAITCNT = 10,
  parameter int CLOCK_CMOS    = 24000000,
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 1,
  parameter int XY_W          = 12
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  input  logic              clk_cmos,
  output logic              cmos_xclk,
  input  logic              cmos_vsync,
  input  logic              cmos_href,
  input  logic [DATA_W-1:0] cmos_data,
`ifdef CMOS_CAPTURE_CROP_EN
  input  logic [XY_W-1:0]   crop_x0,
  input  logic [XY_W-1:0]   crop_y0,
  input  logic [XY_W-1:0]   crop_w,
  input  logic [XY_W-1:0]   crop_h,
`endif
  cmos_capture_multi_if.master frame_bus,
  output logic [XY_W-1:0]   meas_width,
  output logic [XY_W-1:0]   meas_height,
  output logic [7:0]        fps_rate
);

  localparam int PIX_W = BYTES_PER_PIX * DATA_W;
  localparam int WIN_W = $clog2(2 * CLOCK_CMOS);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(2 * CLOCK_CMOS - 1);
  localparam logic [3:0]       WAIT_LIM = 4'(FRAME_WAITCNT);

  assign cmos_xclk = clk_cmos;

  logic              vsync_r0, vsync_r1;
  logic              href_r0, href_r1;
  logic [DATA_W-1:0] data_r0, data_r1;

  logic [3:0]        wait_cnt;
  logic              sync_flag;
  logic [XY_W-1:0]   x_cnt, y_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [8:0]        frame_count;

  logic              de_raw;
  logic [PIX_W-1:0]  pix_data;

  // r1 is the older stage, so r1 & ~r0 marks the last active cycle at r1.
  logic vsync_end, line_end;
  assign vsync_end = vsync_r1 & ~vsync_r0;
  assign line_end  = href_r1 & ~href_r0;

  // Counts as they would be after this cycle's pixel / line, saturating.
  logic [XY_W-1:0] x_after, y_after;
  assign x_after = (de_raw && (x_cnt != '1)) ? x_cnt + 1'b1 : x_cnt;
  assign y_after = (y_cnt != '1) ? y_cnt + 1'b1 : y_cnt;

  generate
    if (BYTES_PER_PIX == 1) begin : g_single
      assign de_raw   = href_r1;
      assign pix_data = data_r1;
    end else begin : g_packed
      logic              phase;
      logic [DATA_W-1:0] first_beat;

      // phase=0 holds the first beat of a pair; an unpaired last beat never
      // reaches phase=1 and is dropped when href falls.
      always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
          phase      <= 1'b0;
          first_beat <= '0;
        end else if (href_r1) begin
          phase <= ~phase;
          if (!phase) first_beat <= data_r1;
        end else begin
          phase <= 1'b0;
        end
      end

      assign de_raw   = href_r1 & phase;
      assign pix_data = {first_beat, data_r1};
    end
  endgenerate

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r0    <= 1'b0;
      vsync_r1    <= 1'b0;
      href_r0     <= 1'b0;
      href_r1     <= 1'b0;
      data_r0     <= '0;
      data_r1     <= '0;
      wait_cnt    <= '0;
      sync_flag   <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      meas_width  <= '0;
      meas_height <= '0;
      win_cnt     <= '0;
      frame_count <= '0;
      fps_rate    <= '0;
    end else begin
      vsync_r0 <= cmos_vsync;
      vsync_r1 <= vsync_r0;
      href_r0  <= cmos_href;
      href_r1  <= href_r0;
      data_r0  <= cmos_data;
      data_r1  <= data_r0;

      if (vsync_end) begin
        if (wait_cnt == WAIT_LIM) sync_flag <= 1'b1;
        else                      wait_cnt  <= wait_cnt + 1'b1;
      end

      if (line_end) begin
        x_cnt      <= '0;
        meas_width <= x_after;
      end else begin
        x_cnt <= x_after;
      end

      // Frame end wins over a coinciding line end for the running count,
      // but the height still includes that final line.
      if (vsync_end) begin
        y_cnt       <= '0;
        meas_height <= line_end ? y_after : y_cnt;
      end else if (line_end) begin
        y_cnt <= y_after;
      end

      if (win_cnt == WIN_LAST) begin
        win_cnt     <= '0;
        fps_rate    <= frame_count[8:1];
        frame_count <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        if (vsync_end) frame_count <= frame_count + 1'b1;
      end
    end
  end

  assign frame_bus.frame_vsync = sync_flag & vsync_r1;
  assign frame_bus.frame_data  = sync_flag ? pix_data : '0;

`ifdef CMOS_CAPTURE_CROP_EN
  // One extra bit so origin + size cannot wrap at the top of the range.
  logic [XY_W:0] x_end, y_end;
  logic          in_x, in_y;
  assign x_end = {1'b0, crop_x0} + {1'b0, crop_w};
  assign y_end = {1'b0, crop_y0} + {1'b0, crop_h};
  assign in_x  = (x_cnt >= crop_x0) && ({1'b0, x_cnt} < x_end);
  assign in_y  = (y_cnt >= crop_y0) && ({1'b0, y_cnt} < y_end);

  assign frame_bus.frame_href = sync_flag & href_r1 & in_y;
  assign frame_bus.frame_de   = sync_flag & de_raw & in_x & in_y;
  assign frame_bus.pix_x      = (sync_flag && in_x) ? x_cnt - crop_x0 : '0;
  assign frame_bus.pix_y      = (sync_flag && in_y) ? y_cnt - crop_y0 : '0;
`else
  assign frame_bus.frame_href = sync_flag & href_r1;
  assign frame_bus.frame_de   = sync_flag & de_raw;
  assign frame_bus.pix_x      = sync_flag ? x_cnt : '0;
  assign frame_bus.pix_y      = sync_flag ? y_cnt : '0;
`endif

endmodule

// File: tb/tb_cmos_capture_multi.sv
// tb/tb_cmos_capture_multi.sv - directed self-checking bench for cmos_capture_multi
module tb_cmos_capture_multi;
  logic       cmos_pclk  = 1'b0;
  logic       clk_cmos   = 1'b0;
  logic       rst_n      = 1'b0;
  logic       cmos_vsync = 1'b0;
  logic       cmos_href  = 1'b0;
  logic [7:0] cmos_data  = 8'h00;

  logic        xclk1, xclk2;
  logic [11:0] mw1, mh1;
  logic [3:0]  mw2, mh2;
  logic [7:0]  fps1, fps2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 cmos_pclk = ~cmos_pclk;
  always #7 clk_cmos  = ~clk_cmos;

  cmos_capture_multi_if #(.DATA_W(8), .BYTES_PER_PIX(1), .XY_W(12)) fif1 ();
  cmos_capture_multi_if #(.DATA_W(8), .BYTES_PER_PIX(2), .XY_W(4))  fif2 ();

`ifdef CMOS_CAPTURE_CROP_EN
  logic [11:0] cx0 = 12'd0, cy0 = 12'd0, cw = 12'hFFF, ch = 12'hFFF;
`endif

  cmos_capture_multi #(
    .FRAME_WAITCNT(2), .CLOCK_CMOS(100), .DATA_W(8), .BYTES_PER_PIX(1), .XY_W(12)
  ) dut (
    .cmos_pclk(cmos_pclk), .rst_n(rst_n), .clk_cmos(clk_cmos), .cmos_xclk(xclk1),
    .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
`ifdef CMOS_CAPTURE_CROP_EN
    .crop_x0(cx0), .crop_y0(cy0), .crop_w(cw), .crop_h(ch),
`endif
    .frame_bus(fif1), .meas_width(mw1), .meas_height(mh1), .fps_rate(fps1)
  );

  cmos_capture_multi #(
    .FRAME_WAITCNT(0), .CLOCK_CMOS(100), .DATA_W(8), .BYTES_PER_PIX(2), .XY_W(4)
  ) dut2 (
    .cmos_pclk(cmos_pclk), .rst_n(rst_n), .clk_cmos(clk_cmos), .cmos_xclk(xclk2),
    .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
`ifdef CMOS_CAPTURE_CROP_EN
    .crop_x0(4'd0), .crop_y0(4'd0), .crop_w(4'hF), .crop_h(4'hF),
`endif
    .frame_bus(fif2), .meas_width(mw2), .meas_height(mh2), .fps_rate(fps2)
  );

  int          de1_total = 0;
  int          de2_total = 0;
  logic [11:0] last_px1 = '0, last_py1 = '0;
  logic [3:0]  last_px2 = '0;
  logic [15:0] d2_prev = '0, d2_last = '0;
  logic [11:0] px_hist [8];
  logic [11:0] py_hist [8];

  always @(negedge cmos_pclk) begin
    if (fif1.frame_de === 1'b1) begin
      px_hist[de1_total % 8] = fif1.pix_x;
      py_hist[de1_total % 8] = fif1.pix_y;
      last_px1 = fif1.pix_x;
      last_py1 = fif1.pix_y;
      de1_total++;
    end
    if (fif2.frame_de === 1'b1) begin
      d2_prev  = d2_last;
      d2_last  = fif2.frame_data;
      last_px2 = fif2.pix_x;
      de2_total++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic h, input logic [7:0] d);
    @(posedge cmos_pclk);
    #1;
    cmos_vsync = v;
    cmos_href  = h;
    cmos_data  = d;
  endtask

  // Frame: 2 vsync-only beats, h lines (last line wl beats) each with 2 gap
  // beats, then 3 idle beats. rst_n is released at beat index rel (-1: none).
  task automatic frame(input int w, input int h, input int wl, input int rel);
    int bi = 0;
    for (int i = 0; i < 2; i++) begin
      beat(1'b1, 1'b0, 8'h00);
      if (bi == rel) rst_n = 1'b1;
      bi++;
    end
    for (int l = 0; l < h; l++) begin
      for (int x = 0; x < ((l == h - 1) ? wl : w); x++) begin
        beat(1'b1, 1'b1, 8'(l * 16 + x));
        if (bi == rel) rst_n = 1'b1;
        bi++;
      end
      for (int g = 0; g < 2; g++) begin
        beat(1'b1, 1'b0, 8'h00);
        if (bi == rel) rst_n = 1'b1;
        bi++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 1'b0, 8'h00);
      if (bi == rel) rst_n = 1'b1;
      bi++;
    end
  endtask

  initial begin
    int s1, s2;
    logic [7:0] eb [5];
    eb[0] = 8'h12; eb[1] = 8'h34; eb[2] = 8'h56; eb[3] = 8'h78; eb[4] = 8'h9A;

    // Reset state
    repeat (3) @(posedge cmos_pclk);
    #1;
    chk("rst_vsync", 32'(fif1.frame_vsync), 0);
    chk("rst_href",  32'(fif1.frame_href), 0);
    chk("rst_de",    32'(fif1.frame_de), 0);
    chk("rst_data",  32'(fif1.frame_data), 0);
    chk("rst_pix",   32'({fif1.pix_x, fif1.pix_y}), 0);
    chk("rst_meas",  32'({mw1, mh1}), 0);
    chk("rst_fps",   32'(fps1), 0);
    chk("rst_meas2", 32'({mw2, mh2, fps2}), 0);

    // Frame rate: 10-cycle frames, reset released inside the first one so
    // the 200-cycle window holds exactly 20 frame ends.
    frame(3, 1, 3, 3);
    for (int f = 1; f < 19; f++) frame(3, 1, 3, -1);
    chk("fps_before_wrap", 32'(fps1), 0);
    for (int f = 0; f < 6; f++) frame(3, 1, 3, -1);
    chk("fps_rate", 32'(fps1), 10);
    chk("fps_rate_dut2", 32'(fps2), 10);

    // Reset pulse mid-line
    beat(1'b1, 1'b0, 8'h00);
    beat(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, 8'h11);
    @(negedge cmos_pclk);
    chk("pre_rst_href", 32'(fif1.frame_href), 1);
    chk("pre_rst_de",   32'(fif1.frame_de), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_href", 32'(fif1.frame_href), 0);
    chk("rst_pulse_de",   32'(fif1.frame_de), 0);
    chk("rst_pulse_data", 32'(fif1.frame_data), 0);
    chk("rst_pulse_meas", 32'(mw1), 0);
    chk("rst_pulse_fps",  32'(fps1), 0);
    beat(1'b1, 1'b1, 8'h11);
    rst_n = 1'b1;
    s1 = de1_total;
    beat(1'b1, 1'b1, 8'h11);
    beat(1'b1, 1'b0, 8'h00);
    beat(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 8'h00);

    // Discard: partial frame + A + B gated on dut, dut2 (wait 0) live in A
    s2 = de2_total;
    frame(8, 4, 8, -1);
    chk("dut2_wait0_de", 32'(de2_total - s2), 16);
    frame(8, 4, 8, -1);
    chk("discard_de", 32'(de1_total - s1), 0);

    // Frame C: first enabled frame
    s1 = de1_total;
    frame(8, 4, 8, -1);
    chk("frameC_de",     32'(de1_total - s1), 32);
    chk("frameC_width",  32'(mw1), 8);
    chk("frameC_height", 32'(mh1), 4);
    chk("frameC_width2", 32'(mw2), 4);

    // Frame D: two-cycle latency from input href to frame_de
    beat(1'b1, 1'b0, 8'h00);
    beat(1'b1, 1'b0, 8'h00);
    beat(1'b1, 1'b1, 8'hA5);
    @(negedge cmos_pclk);
    chk("lat0_de", 32'(fif1.frame_de), 0);
    beat(1'b1, 1'b1, 8'hA6);
    @(negedge cmos_pclk);
    chk("lat1_de", 32'(fif1.frame_de), 0);
    beat(1'b1, 1'b1, 8'hA7);
    @(negedge cmos_pclk);
    chk("lat2_de",   32'(fif1.frame_de), 1);
    chk("lat2_data", 32'(fif1.frame_data), 32'h A5);
    chk("lat2_pix",  32'({fif1.pix_x, fif1.pix_y}), 0);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b1, 8'hB0);
    beat(1'b1, 1'b0, 8'h00);
    beat(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 8'h00);

    // Frame E: 5-beat line into the 2-beat packer
    s2 = de2_total;
    beat(1'b1, 1'b0, 8'h00);
    beat(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b1, eb[i]);
    beat(1'b1, 1'b0, 8'h00);
    beat(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 8'h00);
    chk("pack_de_count", 32'(de2_total - s2), 2);
    chk("pack_first",    32'(d2_prev), 32'h1234);
    chk("pack_second",   32'(d2_last), 32'h5678);
    chk("pack_width",    32'(mw2), 2);
    chk("raw_width",     32'(mw1), 5);
    chk("raw_height",    32'(mh1), 1);

    // Frame F: 480 lines, last one 640 beats
    frame(1, 480, 640, -1);
    chk("big_width",   32'(mw1), 640);
    chk("big_height",  32'(mh1), 480);
    chk("big_last_x",  32'(last_px1), 639);
    chk("big_last_y",  32'(last_py1), 479);
    chk("sat_width2",  32'(mw2), 15);
    chk("sat_height2", 32'(mh2), 15);
`ifndef CMOS_CAPTURE_CROP_EN
    chk("sat_pix_x2",  32'(last_px2), 15);
`endif

`ifdef CMOS_CAPTURE_CROP_EN
    cx0 = 12'd2; cy0 = 12'd1; cw = 12'd3; ch = 12'd2;
    s1 = de1_total;
    frame(8, 4, 8, -1);
    chk("crop_de_count", 32'(de1_total - s1), 6);
    chk("crop_first_x",  32'(px_hist[s1 % 8]), 0);
    chk("crop_first_y",  32'(py_hist[s1 % 8]), 0);
    chk("crop_meas_w",   32'(mw1), 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cmos_capture_multi.md
CMOS_CAPTURE_MULTI -- requirements
Module: cmos_capture_multi

Interface
REQ-001 SHALL provide parameter FRAME_WAITCNT, default 10: number of complete frames discarded after reset before output is enabled (range 0..15).
REQ-002 SHALL provide parameter CLOCK_CMOS, default 24000000: cmos_pclk frequency in Hz, used for the fps window.
REQ-003 SHALL provide parameter DATA_W, default 8: sensor bus width (range 8..12).
REQ-004 SHALL provide parameter BYTES_PER_PIX, default 1: sensor beats per pixel (1 = RAW/gray, 2 = packed, e.g. RGB565).
REQ-005 SHALL provide parameter XY_W, default 12: width of the coordinate and size counters.
REQ-006 SHALL have port cmos_pclk, input, 1: pixel clock; all logic runs on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port clk_cmos, input, 1: sensor drive clock.
REQ-009 SHALL have port cmos_xclk, output, 1: continuous assignment of clk_cmos.
REQ-010 SHALL have ports cmos_vsync, cmos_href, input, 1 each: frame-valid and line-valid, both active high.
REQ-011 SHALL have port cmos_data, input, DATA_W: sensor data.
REQ-012 SHALL have ports frame_vsync, frame_href, frame_de, output, 1 each: gated vsync, gated href, pixel-valid strobe.
REQ-013 SHALL have port frame_data, output, BYTES_PER_PIX*DATA_W: pixel data.
REQ-014 SHALL have ports pix_x, pix_y, output, XY_W each: coordinates of the current frame_de pixel.
REQ-015 SHALL have ports meas_width, meas_height, output, XY_W each: pixel count of the last complete line and line count of the last complete frame.
REQ-016 SHALL have port fps_rate, output, 8: frames per second, averaged over 2 s.

Function
REQ-017 SHALL pass vsync, href and data through a 2-stage register pipeline (stage r0, then stage r1); vsync_end SHALL be defined as vsync_r1 AND NOT vsync_r0.
REQ-018 SHALL count vsync_end events in a counter that saturates at FRAME_WAITCNT.
REQ-019 SHALL set a sticky sync_flag on the first vsync_end at which the counter equals FRAME_WAITCNT; with FRAME_WAITCNT=0 this is the first vsync_end after reset.
REQ-020 While sync_flag=0, frame_vsync, frame_href, frame_de, frame_data, pix_x and pix_y SHALL all be 0.
REQ-021 When BYTES_PER_PIX=1: frame_de SHALL equal href_r1 and frame_data SHALL equal data_r1, giving 2 cycles of latency from input.
REQ-022 When BYTES_PER_PIX=2: a beat-phase bit SHALL clear on each href_r1 low cycle and toggle on each href_r1 high cycle.
REQ-023 When BYTES_PER_PIX=2: frame_de SHALL assert on cycles where href_r1=1 and phase=1, with frame_data = {first beat, second beat} (first beat in the MSBs).
REQ-024 When BYTES_PER_PIX=2: an odd trailing beat at the end of a line SHALL be discarded.
REQ-025 pix_x SHALL increment after each frame_de, reset to 0 on the href_r1 falling edge, and saturate at all-ones.
REQ-026 pix_y SHALL increment on each href_r1 falling edge, reset to 0 on vsync_end, and saturate at all-ones.
REQ-027 meas_width SHALL latch the line's pixel count on the href_r1 falling edge.
REQ-028 meas_height SHALL latch the frame's line count on vsync_end; both measurements SHALL update regardless of sync_flag.
REQ-029 A window counter SHALL count 0..2*CLOCK_CMOS-1 and wrap; a frame counter (9 bits) SHALL count vsync_end events within the window.
REQ-030 On window wrap: fps_rate SHALL load frame_count[8:1] and the frame counter SHALL clear to 0; a vsync_end in the wrap cycle SHALL be dropped.
REQ-031 A vsync_end that coincides with a line end SHALL apply both updates in the same cycle, with the pix_y reset taking priority.

Reset
REQ-032 rst_n low SHALL asynchronously clear all pipeline registers, counters, phase, sync_flag, meas_width, meas_height and fps_rate to 0.
REQ-033 A reset asserted mid-frame SHALL restart the FRAME_WAITCNT discard sequence.

Configuration
REQ-034 With macro CMOS_CAPTURE_CROP_EN defined, the block SHALL add XY_W-bit inputs crop_x0, crop_y0, crop_w and crop_h.
REQ-035 With CMOS_CAPTURE_CROP_EN defined, frame_de SHALL assert only when crop_x0 <= x < crop_x0+crop_w and crop_y0 <= y < crop_y0+crop_h, using pre-crop coordinates.
REQ-036 With CMOS_CAPTURE_CROP_EN defined, frame_href SHALL assert only on lines inside the crop window; pix_x and pix_y SHALL be window-relative; meas_* SHALL remain full-frame.
REQ-037 Without CMOS_CAPTURE_CROP_EN, the crop ports SHALL be absent and the full frame SHALL be output.

Verification
REQ-038 FRAME_WAITCNT=2, 4 frames of 8x4 -> output zero during frames 1-3; frames 4+ output; frame_de exactly 2 cycles after input href.
REQ-039 BYTES_PER_PIX=2, line bytes 0x12,0x34,0x56,0x78,0x9A -> frame_de twice with data 0x1234 then 0x5678; 0x9A dropped; meas_width=2.
REQ-040 Frames of 640 beats x 480 lines -> meas_width=640, meas_height=480; pix_x/pix_y run 0..639/0..479.
REQ-041 CLOCK_CMOS=100, one frame every 10 cycles -> fps_rate=10 after the first 200-cycle window.
REQ-042 rst_n pulsed mid-line -> all outputs 0 immediately; the discard sequence restarts.
REQ-043 CMOS_CAPTURE_CROP_EN, 8x4 frame, window (2,1,3,2) -> 6 frame_de pulses; first pixel has pix_x=0, pix_y=0.
